shiftreg_fifo_fwft: RTL and testbench
=====================================

SHIFTREG_FIFO_FWFT -- requirements
Module: shiftreg_fifo_fwft

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the shift-register address width; DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the shift-register entries; DEPTH >= 2; total capacity is DEPTH+1, counting the output register.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-1, meaning if_almost_full asserts when occupancy >= AFULL_THRESH; range 1..DEPTH+1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port if_write_ce, input, 1 bit: write-side clock enable.
REQ-008 SHALL have port if_write, input, 1 bit: write request.
REQ-009 SHALL have port if_din, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port if_full_n, output, 1 bit: high when the FIFO can accept a word.
REQ-011 SHALL have port if_read_ce, input, 1 bit: read-side clock enable.
REQ-012 SHALL have port if_read, input, 1 bit: read (pop) request.
REQ-013 SHALL have port if_dout, output, DATA_WIDTH bits: head word, valid while if_empty_n=1.
REQ-014 SHALL have port if_empty_n, output, 1 bit: high when if_dout holds a valid word.
REQ-015 SHALL have port if_num_data, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH+1.
REQ-016 SHALL have port if_almost_full, output, 1 bit: high when occupancy >= AFULL_THRESH.

Function
REQ-017 push SHALL equal if_write & if_write_ce & if_full_n.
REQ-018 pop SHALL equal if_read & if_read_ce & if_empty_n.
REQ-019 Storage SHALL be a DEPTH-entry shift array; a push into the array shifts every entry up by one and loads if_din at index 0; the array itself is never reset.
REQ-020 The oldest array entry SHALL be read at index addr = (array count - 1); array count is 0..DEPTH.
REQ-021 Output register SHALL be first-word-fall-through: a push into a completely empty FIFO loads if_din directly into if_dout, with if_empty_n=1 on the next cycle (latency 1).
REQ-022 On a pop with array count > 0, if_dout SHALL load the oldest array entry and array count SHALL decrement, adjusted for any simultaneous push.
REQ-023 On a pop with array count = 0 and a simultaneous push, if_dout SHALL load if_din and if_empty_n SHALL stay 1.
REQ-024 On a pop with array count = 0 and no push, if_empty_n SHALL go 0 next cycle; if_dout SHALL hold its last value.
REQ-025 On a push while the output register is valid, the word SHALL enter the array; a simultaneous push and pop SHALL leave if_num_data unchanged.
REQ-026 if_num_data SHALL be +1 on push only, -1 on pop only, and unchanged otherwise; it SHALL never exceed DEPTH+1 or go below 0.
REQ-027 if_full_n, if_empty_n and if_almost_full SHALL be registered, derived from next-state occupancy, with no combinational path from inputs.
REQ-028 At full (occupancy DEPTH+1), if_full_n=0, so a write is ignored even if a pop occurs the same cycle; if_full_n SHALL return to 1 the cycle after that pop.
REQ-029 When empty, if_read SHALL be ignored and no state SHALL change.
REQ-030 With if_write_ce=0 or if_read_ce=0, the corresponding side SHALL be fully stalled regardless of if_write or if_read.
REQ-031 Data order SHALL be strict FIFO with no loss or duplication under any interleaving.

Reset
REQ-032 While reset=1 at a clock edge: if_empty_n=0, if_full_n=1, if_num_data=0, if_almost_full=0, if_dout=0, array count=0.
REQ-033 Reset SHALL take priority over a simultaneous push or pop; contents in flight are discarded and array contents are don't-care afterwards.
REQ-034 After reset deasserts, the first push SHALL behave as a push into an empty FIFO (REQ-021).

Verification
REQ-035 Empty-FIFO push: push 0xA5 on cycle 0 -> on cycle 1, if_empty_n=1, if_dout=0xA5, if_num_data=1.
REQ-036 Fill with DEPTH=16: 17 pushes of 0..16 -> if_full_n=0 and if_num_data=17; if_almost_full=1 from occupancy 15; an 18th write is ignored; popping 17 words gives 0..16 in order.
REQ-037 Simultaneous push and pop at occupancy 1, 5 and 17 -> if_num_data is unchanged at 1 and 5 with order preserved; at 17, only the pop takes effect (if_num_data=16).
REQ-038 CE gating: if_write=1 with if_write_ce=0 for 4 cycles -> no occupancy change; if_read=1 with if_read_ce=0 -> if_dout stays stable.
REQ-039 Reset mid-stream at occupancy 9 with push and pop active -> next cycle all outputs are at the REQ-032 values; a subsequent push of 0x3C appears on if_dout one cycle later.
REQ-040 Random push/pop for 10k cycles against a reference queue model -> zero mismatches; if_num_data always equals the model's occupancy.

Source files
------------

// File: rtl/shiftreg_fifo_fwft.sv
// First-word-fall-through FIFO built from a shift-register array plus an output register.
// Capacity is DEPTH+1 words. The head word is always presented on if_dout.
module shiftreg_fifo_fwft #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data,
  output logic                  if_almost_full
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      arr_cnt, arr_cnt_nxt;
  logic [CNT_W-1:0]      num_data, num_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] dout, dout_nxt;
  logic                  empty_n, empty_n_nxt;
  logic                  full_n, almost_full;
  logic                  push, pop, shift_in;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    push        = if_write & if_write_ce & full_n;
    pop         = if_read & if_read_ce & empty_n;
    addr        = ADDR_WIDTH'(arr_cnt - 1'b1);
    dout_nxt    = dout;
    empty_n_nxt = empty_n;
    arr_cnt_nxt = arr_cnt;
    shift_in    = 1'b0;

    if (!empty_n) begin
      // Empty FIFO: the pushed word bypasses the array straight into the output register.
      if (push) begin
        dout_nxt    = if_din;
        empty_n_nxt = 1'b1;
      end
    end else if (pop) begin
      if (arr_cnt != '0) begin
        dout_nxt    = mem[addr];
        shift_in    = push;
        arr_cnt_nxt = push ? arr_cnt : arr_cnt - 1'b1;
      end else if (push) begin
        dout_nxt = if_din;
      end else begin
        empty_n_nxt = 1'b0;
      end
    end else if (push) begin
      shift_in    = 1'b1;
      arr_cnt_nxt = arr_cnt + 1'b1;
    end

    num_nxt = num_data;
    if (push && !pop)      num_nxt = num_data + 1'b1;
    else if (pop && !push) num_nxt = num_data - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout        <= '0;
      empty_n     <= 1'b0;
      full_n      <= 1'b1;
      almost_full <= 1'b0;
      num_data    <= '0;
      arr_cnt     <= '0;
    end else begin
      dout        <= dout_nxt;
      empty_n     <= empty_n_nxt;
      full_n      <= (num_nxt != FULL_CNT);
      almost_full <= (num_nxt >= AFULL_CNT);
      num_data    <= num_nxt;
      arr_cnt     <= arr_cnt_nxt;
    end
  end

  // NOTE: the storage array is deliberately not reset; arr_cnt alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (shift_in) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= if_din;
    end
  end

  assign if_dout        = dout;
  assign if_empty_n     = empty_n;
  assign if_full_n      = full_n;
  assign if_almost_full = almost_full;
  assign if_num_data    = num_data;

endmodule

// File: tb/tb_shiftreg_fifo_fwft.sv
// Directed and randomized checks for shiftreg_fifo_fwft at its default parameters.
// A reference queue tracks expected contents for the random phase.
module tb_shiftreg_fifo_fwft;

  logic        clk = 1'b0;
  logic        reset;
  logic        wce, wr, rce, rd;
  logic [31:0] din;
  logic [31:0] dout;
  logic        full_n, empty_n, almost_full;
  logic [4:0]  num_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] q [$];

  always #5 clk = ~clk;

  shiftreg_fifo_fwft dut (
    .clk(clk), .reset(reset),
    .if_write_ce(wce), .if_write(wr), .if_din(din), .if_full_n(full_n),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout), .if_empty_n(empty_n),
    .if_num_data(num_data), .if_almost_full(almost_full)
  );

  // One clock with the given inputs; the model queue mirrors the accepted push/pop.
  task automatic step(input logic w, input logic r, input logic wc, input logic rc,
                      input logic [31:0] d);
    bit do_push, do_pop;
    wr = w; rd = r; wce = wc; rce = rc; din = d;
    do_push = w && wc && (q.size() < 17);
    do_pop  = r && rc && (q.size() > 0);
    @(posedge clk); #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    wr = 1'b0; rd = 1'b0; wce = 1'b1; rce = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty_n !== 1'b0) begin failures++; $display("FAIL reset_empty_n got=%b exp=0", empty_n); end
    checks++; if (full_n !== 1'b1) begin failures++; $display("FAIL reset_full_n got=%b exp=1", full_n); end
    checks++; if (num_data !== 5'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", num_data); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
  endtask

  task automatic test_empty_push();
    step(1, 0, 1, 1, 32'hA5);
    checks++; if (empty_n !== 1'b1) begin failures++; $display("FAIL ep_empty_n got=%b exp=1", empty_n); end
    checks++; if (dout !== 32'hA5) begin failures++; $display("FAIL ep_dout got=%h exp=a5", dout); end
    checks++; if (num_data !== 5'd1) begin failures++; $display("FAIL ep_num got=%0d exp=1", num_data); end
    step(0, 1, 1, 1, 0);
    checks++; if (empty_n !== 1'b0) begin failures++; $display("FAIL ep_pop_empty_n got=%b exp=0", empty_n); end
    checks++; if (dout !== 32'hA5) begin failures++; $display("FAIL ep_pop_hold got=%h exp=a5", dout); end
    step(0, 1, 1, 1, 0);
    checks++; if (num_data !== 5'd0 || empty_n !== 1'b0) begin
      failures++; $display("FAIL ep_read_empty num=%0d empty_n=%b exp=0/0", num_data, empty_n); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 1, 1, 32'(i));
      checks++; if (num_data !== 5'(i + 1)) begin failures++; $display("FAIL fill_num[%0d] got=%0d exp=%0d", i, num_data, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 15)) begin failures++; $display("FAIL fill_afull[%0d] got=%b", i, almost_full); end
      checks++; if (full_n !== (i + 1 != 17)) begin failures++; $display("FAIL fill_full_n[%0d] got=%b", i, full_n); end
      checks++; if (dout !== 32'd0) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=0", i, dout); end
    end
    step(1, 0, 1, 1, 32'd99);
    checks++; if (num_data !== 5'd17) begin failures++; $display("FAIL fill_overwrite_num got=%0d exp=17", num_data); end
    for (int i = 0; i < 17; i++) begin
      checks++; if (dout !== 32'(i)) begin failures++; $display("FAIL drain[%0d] got=%h exp=%h", i, dout, i); end
      step(0, 1, 1, 1, 0);
      if (i == 0) begin
        checks++; if (full_n !== 1'b1) begin failures++; $display("FAIL full_n_return got=%b exp=1", full_n); end
      end
    end
    checks++; if (empty_n !== 1'b0 || num_data !== 5'd0) begin
      failures++; $display("FAIL drain_end empty_n=%b num=%0d exp=0/0", empty_n, num_data); end
  endtask

  task automatic test_simultaneous();
    int occ [3] = '{1, 5, 17};
    foreach (occ[k]) begin
      for (int i = 0; i < occ[k]; i++) step(1, 0, 1, 1, 32'h100 * (k + 1) + 32'(i));
      step(1, 1, 1, 1, 32'hBEEF0000 + 32'(k));
      checks++;
      if (num_data !== 5'(occ[k] == 17 ? 16 : occ[k])) begin
        failures++; $display("FAIL simul_num[occ=%0d] got=%0d", occ[k], num_data); end
      checks++;
      if (dout !== (occ[k] == 1 ? 32'hBEEF0000 + 32'(k) : 32'h100 * (k + 1) + 32'd1)) begin
        failures++; $display("FAIL simul_head[occ=%0d] got=%h", occ[k], dout); end
      while (q.size() > 0) begin
        checks++; if (dout !== q[0]) begin failures++; $display("FAIL simul_order[occ=%0d] got=%h exp=%h", occ[k], dout, q[0]); end
        step(0, 1, 1, 1, 0);
      end
      checks++; if (empty_n !== 1'b0) begin failures++; $display("FAIL simul_drained[occ=%0d] empty_n=%b", occ[k], empty_n); end
    end
  endtask

  task automatic test_ce_gating();
    step(1, 0, 1, 1, 32'h11);
    step(1, 0, 1, 1, 32'h22);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 32'h33);
      checks++; if (num_data !== 5'd2) begin failures++; $display("FAIL wce_num[%0d] got=%0d exp=2", i, num_data); end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 0);
      checks++; if (dout !== 32'h11 || num_data !== 5'd2) begin
        failures++; $display("FAIL rce_hold[%0d] dout=%h num=%0d exp=11/2", i, dout, num_data); end
    end
    step(0, 1, 1, 1, 0);
    checks++; if (dout !== 32'h22) begin failures++; $display("FAIL ce_release got=%h exp=22", dout); end
    step(0, 1, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1, 0, 1, 1, 32'h50 + 32'(i));
    checks++; if (num_data !== 5'd9) begin failures++; $display("FAIL mid_pre_num got=%0d exp=9", num_data); end
    reset = 1'b1; wr = 1'b1; rd = 1'b1; din = 32'h77;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
    q.delete();
    checks++; if (empty_n !== 1'b0 || full_n !== 1'b1 || num_data !== 5'd0 || almost_full !== 1'b0 || dout !== 32'h0) begin
      failures++; $display("FAIL mid_reset empty_n=%b full_n=%b num=%0d afull=%b dout=%h", empty_n, full_n, num_data, almost_full, dout); end
    step(1, 0, 1, 1, 32'h3C);
    checks++; if (dout !== 32'h3C || empty_n !== 1'b1 || num_data !== 5'd1) begin
      failures++; $display("FAIL mid_first_push dout=%h empty_n=%b num=%0d exp=3c/1/1", dout, empty_n, num_data); end
  endtask

  task automatic test_random();
    logic [31:0] last;
    do_reset();
    last = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      // Bias the push rate in phases so both full and empty regions are visited.
      int wp = ((c / 500) % 2 == 0) ? 70 : 30;
      step($urandom_range(99) < wp, $urandom_range(99) < 50,
           $urandom_range(9) != 0, $urandom_range(9) != 0, $urandom);
      if (q.size() > 0) last = q[0];
      checks++;
      if (num_data !== 5'(q.size()) || empty_n !== (q.size() > 0) || full_n !== (q.size() < 17) ||
          almost_full !== (q.size() >= 15) || dout !== last) begin
        failures++;
        $display("FAIL random[%0d] num=%0d/%0d empty_n=%b full_n=%b afull=%b dout=%h exp_dout=%h",
                 c, num_data, q.size(), empty_n, full_n, almost_full, dout, last);
      end
    end
  endtask

  initial begin
    reset = 1'b0; wce = 1'b1; wr = 1'b0; rce = 1'b1; rd = 1'b0; din = '0;
    @(posedge clk); #1;
    test_reset();
    test_empty_push();
    test_fill();
    test_simultaneous();
    test_ce_gating();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
